ext_intr_gen: RTL and testbench

EXT_INTR_GEN -- requirements
Module: ext_intr_gen

---
 rtl/intr_pkg.sv | 15 +
 rtl/intr_sync_edge.sv | 48 ++++
 rtl/ext_intr_gen.sv | 103 ++++++++++
 tb/tb_ext_intr_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the external interrupt generator: default sizing
// and the request/service FSM encoding.
package intr_pkg;

  localparam int NSRC_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

endpackage

// File: rtl/intr_sync_edge.sv
// One interrupt source: multi-flop synchronizer, previous-value edge detect
// and the registered pending bit (sticky for edge mode, follower for level).
module intr_sync_edge
  import intr_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  input  logic edge_mode_i,
  input  logic clr_i,
  output logic pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pend_q;
  logic                   pend_d;
  logic                   synced;
  logic                   rise;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

  // A new rising edge beats a same-cycle acknowledge so no event is lost.
  always_comb begin
    pend_d = synced;
    if (edge_mode_i) begin
      pend_d = rise | (pend_q & ~clr_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= synced;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/ext_intr_gen.sv
// External interrupt generator: per-source sync/pend, fixed lowest-index
// priority arbitration and the IDLE/REQ/SERVICE/GAP request FSM.
module ext_intr_gen
  import intr_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int IDW        = $clog2(NSRC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_pin,
  input  logic [NSRC-1:0] cfg_edge,
  input  logic [NSRC-1:0] cfg_mask,
  input  logic            intr_ack,
  input  logic            ertn_w,
  output logic            ext_intr,
  output logic [IDW-1:0]  ext_intr_id,
  output logic [NSRC-1:0] pend,
  output logic            in_service,
  output state_e          dbg_state_o
);

  // Core handshake: ext_intr is a level held in REQ; intr_ack is a one-cycle
  // pulse honoured only in REQ, ertn_w a one-cycle pulse honoured only in
  // SERVICE. Pulses arriving in any other state are dropped.

  state_e          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  win_idx;
  logic            withdraw;
  logic            take_ack;

  assign take_ack = (state_q == ST_REQ) && intr_ack;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign clr[g] = take_ack && (id_q == IDW'(g));

    intr_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk        (clk),
      .reset      (reset),
      .pin_i      (irq_pin[g]),
      .edge_mode_i(cfg_edge[g]),
      .clr_i      (clr[g]),
      .pend_o     (pend[g])
    );
  end

  assign cand = pend & cfg_mask;

  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDW'(i);
    end
  end

  // Edge pend cannot drop while in REQ, so only level sources can withdraw
  // by pend; any source withdraws when masked.
  assign withdraw = ~cfg_mask[id_q] | (~cfg_edge[id_q] & ~pend[id_q]);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          state_d = ST_REQ;
          id_d    = win_idx;
        end
      end
      ST_REQ: begin
        if (intr_ack)      state_d = ST_SERVICE;
        else if (withdraw) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (ertn_w) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign ext_intr    = (state_q == ST_REQ);
  assign in_service  = (state_q == ST_SERVICE);
  assign ext_intr_id = id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ext_intr_gen.sv
// Directed bench for ext_intr_gen: latency, priority, withdrawal, masking,
// ack/ertn collisions and reset during service, with hand-computed results.
module tb_ext_intr_gen;
  import intr_pkg::*;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_pin;
  logic [NSRC-1:0] cfg_edge;
  logic [NSRC-1:0] cfg_mask;
  logic            intr_ack;
  logic            ertn_w;
  logic            ext_intr;
  logic [IDW-1:0]  ext_intr_id;
  logic [NSRC-1:0] pend;
  logic            in_service;
  state_e          dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ext_intr_gen #(
    .NSRC       (NSRC),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_pin    (irq_pin),
    .cfg_edge   (cfg_edge),
    .cfg_mask   (cfg_mask),
    .intr_ack   (intr_ack),
    .ertn_w     (ertn_w),
    .ext_intr   (ext_intr),
    .ext_intr_id(ext_intr_id),
    .pend       (pend),
    .in_service (in_service),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_pins(input logic [NSRC-1:0] m);
    irq_pin = irq_pin | m;
    tick();
    irq_pin = irq_pin & ~m;
  endtask

  task automatic do_ack();
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
  endtask

  task automatic do_ertn();
    ertn_w = 1'b1;
    tick();
    ertn_w = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [IDW-1:0] id);
    chk({tag, "_intr"}, 32'(ext_intr), 32'd1);
    chk({tag, "_id"}, 32'(ext_intr_id), 32'(id));
    chk({tag, "_st"}, 32'(dbg_state), 32'(ST_REQ));
  endtask

  initial begin
    reset    = 1'b1;
    irq_pin  = '0;
    cfg_edge = 4'b1111;
    cfg_mask = 4'b1111;
    intr_ack = 1'b0;
    ertn_w   = 1'b0;
    #1;
    chk("rst_intr", 32'(ext_intr), 32'd0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_id", 32'(ext_intr_id), 32'd0);
    tick(2);
    reset = 1'b0;
    tick();
    chk("post_rst_st", 32'(dbg_state), 32'(ST_IDLE));

    // Edge source 2: request visible 4 cycles after pin rise.
    pulse_pins(4'b0100);
    tick(2);
    chk("lat_pend", 32'(pend), 32'h4);
    chk("lat_early", 32'(ext_intr), 32'd0);
    tick();
    chk_req("lat", 2'd2);
    do_ack();
    chk("ack_intr", 32'(ext_intr), 32'd0);
    chk("ack_pend", 32'(pend), 32'h0);
    chk("ack_insvc", 32'(in_service), 32'd1);
    chk("ack_id", 32'(ext_intr_id), 32'd2);
    do_ertn();
    chk("gap_st", 32'(dbg_state), 32'(ST_GAP));
    chk("gap_insvc", 32'(in_service), 32'd0);
    tick();
    chk("idle_st", 32'(dbg_state), 32'(ST_IDLE));

    // Sources 1 and 3 together: 1 wins, 3 follows after the gap.
    pulse_pins(4'b1010);
    tick(3);
    chk("pri_pend", 32'(pend), 32'ha);
    chk_req("pri1", 2'd1);
    do_ack();
    chk("pri_pend_ack", 32'(pend), 32'h8);
    do_ertn();
    chk("pri_gap_intr", 32'(ext_intr), 32'd0);
    chk("pri_gap_st", 32'(dbg_state), 32'(ST_GAP));
    tick();
    chk("pri_idle_intr", 32'(ext_intr), 32'd0);
    tick();
    chk_req("pri3", 2'd3);
    do_ack();
    do_ertn();
    tick(2);
    chk("pri_done_pend", 32'(pend), 32'h0);
    chk("pri_done_st", 32'(dbg_state), 32'(ST_IDLE));

    // Level source 0 withdraws before ack.
    cfg_edge = 4'b1110;
    irq_pin[0] = 1'b1;
    tick(4);
    chk_req("lvl", 2'd0);
    chk("lvl_pend", 32'(pend), 32'h1);
    irq_pin[0] = 1'b0;
    tick(3);
    chk("lvl_hold_intr", 32'(ext_intr), 32'd1);
    chk("lvl_pend_drop", 32'(pend), 32'h0);
    tick();
    chk("lvl_wd_intr", 32'(ext_intr), 32'd0);
    chk("lvl_wd_st", 32'(dbg_state), 32'(ST_IDLE));
    tick(2);
    chk("lvl_stay_st", 32'(dbg_state), 32'(ST_IDLE));
    cfg_edge = 4'b1111;

    // Masked source 2 records pend; unmasking triggers arbitration.
    cfg_mask = 4'b1011;
    pulse_pins(4'b0100);
    tick(4);
    chk("msk_pend", 32'(pend), 32'h4);
    chk("msk_intr", 32'(ext_intr), 32'd0);
    chk("msk_st", 32'(dbg_state), 32'(ST_IDLE));
    cfg_mask = 4'b1111;
    tick(2);
    chk_req("unmsk", 2'd2);
    do_ertn();
    chk_req("ertn_in_req", 2'd2);

    // Ack and ertn together in REQ go to SERVICE; re-pulse during SERVICE.
    intr_ack = 1'b1;
    ertn_w   = 1'b1;
    tick();
    intr_ack = 1'b0;
    ertn_w   = 1'b0;
    chk("both_st", 32'(dbg_state), 32'(ST_SERVICE));
    chk("both_pend", 32'(pend), 32'h0);
    pulse_pins(4'b0100);
    tick(2);
    chk("svc_pend", 32'(pend), 32'h4);
    chk("svc_intr", 32'(ext_intr), 32'd0);
    do_ack();
    chk("svc_ack_ign_st", 32'(dbg_state), 32'(ST_SERVICE));
    chk("svc_ack_ign_pend", 32'(pend), 32'h4);
    do_ertn();
    chk("re_gap_st", 32'(dbg_state), 32'(ST_GAP));
    tick(2);
    chk_req("re_req", 2'd2);
    do_ack();
    do_ertn();
    tick(2);

    // Reset while servicing source 0 with source 1 still pending.
    pulse_pins(4'b0011);
    tick(3);
    chk_req("rs_req", 2'd0);
    do_ack();
    chk("rs_svc_pend", 32'(pend), 32'h2);
    chk("rs_svc_insvc", 32'(in_service), 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_intr", 32'(ext_intr), 32'd0);
    chk("rs_insvc", 32'(in_service), 32'd0);
    chk("rs_pend", 32'(pend), 32'h0);
    chk("rs_id", 32'(ext_intr_id), 32'd0);
    tick();
    reset = 1'b0;
    tick(6);
    chk("rs_after_intr", 32'(ext_intr), 32'd0);
    chk("rs_after_pend", 32'(pend), 32'h0);
    chk("rs_after_st", 32'(dbg_state), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
